// File: rtl/seq_shifter.sv
// seq_shifter: iterative shift/rotate register.
// A word is loaded on start and then shifted by up to STEP bits per clock
// until the requested amount is consumed. Modes: SLL, SRL, SRA, ROL, ROR.
// Codes 5-7 are hold modes: they count down like a real op but leave q alone.
//
// Handshake: start is sampled only while busy==0 (IDLE). After the start
// edge, busy stays high through SHIFT and DONE. done is high for exactly one
// cycle (the DONE state), and q is final in that cycle. The FSM then returns
// to IDLE for at least one cycle before another start can be taken.
module seq_shifter #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  localparam int AW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ld,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    amt,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  localparam logic [AW-1:0] STEP_W = AW'(STEP);

  state_t           state_q;
  state_t           state_d;
  logic [AW-1:0]    rem_q;
  logic [2:0]       op_q;
  logic [AW-1:0]    n_amt;
  logic [WIDTH-1:0] shift_q;
  logic             shift_bit;
  logic             op_real;
  int               n;

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign op_real = (op_q <= OP_ROR);

  // Next-state logic: zero amount skips SHIFT; last step is the one with rem<=STEP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (rem_q <= STEP_W) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // One shift step of n=min(STEP,rem) bits plus the bit that leaves the register.
  always_comb begin
    n_amt     = (rem_q < STEP_W) ? rem_q : STEP_W;
    // n is never 0 in SHIFT; clamp so the bit selects below stay in range elsewhere.
    n         = (n_amt == '0) ? 1 : int'(n_amt);
    shift_q   = q;
    shift_bit = ser_out;
    for (int i = 0; i < WIDTH; i++) begin
      case (op_q)
        OP_SLL:  shift_q[i] = (i >= n) ? q[i-n] : ser_in;
        OP_SRL:  shift_q[i] = (i + n < WIDTH) ? q[i+n] : ser_in;
        OP_SRA:  shift_q[i] = (i + n < WIDTH) ? q[i+n] : q[WIDTH-1];
        OP_ROL:  shift_q[i] = q[(i - n + WIDTH) % WIDTH];
        OP_ROR:  shift_q[i] = q[(i + n) % WIDTH];
        default: shift_q[i] = q[i];
      endcase
    end
    case (op_q)
      OP_SLL, OP_ROL:         shift_bit = q[WIDTH-n];
      OP_SRL, OP_SRA, OP_ROR: shift_bit = q[n-1];
      default:                shift_bit = ser_out;
    endcase
  end

  // State register and datapath; reset also aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      q       <= '0;
      ser_out <= 1'b0;
      rem_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            q     <= d;
            rem_q <= amt;
            op_q  <= op;
          end else if (ld) begin
            q <= d;
          end
        end
        SHIFT: begin
          rem_q <= rem_q - n_amt;
          if (op_real) begin
            q       <= shift_q;
            ser_out <= shift_bit;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: directed tests for seq_shifter.
// Two instances share all inputs: dut1 (STEP=1) and dut4 (STEP=4), both WIDTH=8.
// Inputs change 1ns after a rising edge; outputs are checked at the same point,
// so every check sees the result of the edge just taken.
module tb_seq_shifter;

  logic       clk;
  logic       rst;
  logic       start;
  logic       ld;
  logic [2:0] op;
  logic [2:0] amt;
  logic [7:0] d;
  logic       ser_in;
  logic [7:0] q1, q4;
  logic       so1, so4, busy1, busy4, done1, done4;

  int n_cmp = 0;
  int n_bad = 0;

  seq_shifter #(.WIDTH(8), .STEP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .ld(ld), .op(op), .amt(amt), .d(d),
    .ser_in(ser_in), .q(q1), .ser_out(so1), .busy(busy1), .done(done1)
  );

  seq_shifter #(.WIDTH(8), .STEP(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .ld(ld), .op(op), .amt(amt), .d(d),
    .ser_in(ser_in), .q(q4), .ser_out(so4), .busy(busy4), .done(done4)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [2:0] a, input logic [7:0] dv, input logic si);
    op = o; amt = a; d = dv; ser_in = si; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits (bounded) for done1 after the start edge; lat = edges after E0.
  task automatic wait_done1(output int lat, output logic seen);
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      tick();
      if (done1) begin
        seen = 1'b1;
        lat  = i;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; ld = 1'b0; op = 3'd0; amt = 3'd0; d = 8'h00; ser_in = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (q1 !== 8'h00) begin n_bad++; $display("FAIL reset_q1 got %h want 00", q1); end
    n_cmp++; if ({busy1, done1, so1} !== 3'b000) begin n_bad++; $display("FAIL reset_flags1 got %b want 000", {busy1, done1, so1}); end
    n_cmp++; if ({q4, busy4, done4, so4} !== 11'h000) begin n_bad++; $display("FAIL reset_dut4 got %h want 000", {q4, busy4, done4, so4}); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_sll();
    issue(3'd0, 3'd3, 8'hB1, 1'b0);  // E0
    n_cmp++; if ({busy1, done1, q1} !== {2'b10, 8'hB1}) begin n_bad++; $display("FAIL sll_e0 got %b %b %h want 1 0 b1", busy1, done1, q1); end
    ld = 1'b1; d = 8'hFF; op = 3'd1;  // must be ignored while busy
    tick();                           // E1
    ld = 1'b0; d = 8'h00;
    n_cmp++; if ({q1, so1} !== {8'h62, 1'b1}) begin n_bad++; $display("FAIL sll_e1 got %h %b want 62 1", q1, so1); end
    tick();                           // E2
    n_cmp++; if ({q1, so1, done1} !== {8'hC4, 2'b00}) begin n_bad++; $display("FAIL sll_e2 got %h %b %b want c4 0 0", q1, so1, done1); end
    tick();                           // E3
    n_cmp++; if ({q1, so1, done1, busy1} !== {8'h88, 3'b111}) begin n_bad++; $display("FAIL sll_e3 got %h %b %b %b want 88 1 1 1", q1, so1, done1, busy1); end
    tick();                           // E4
    n_cmp++; if ({q1, done1, busy1} !== {8'h88, 2'b00}) begin n_bad++; $display("FAIL sll_e4 got %h %b %b want 88 0 0", q1, done1, busy1); end
  endtask

  task automatic test_sra_srl();
    int   lat;
    logic seen;
    issue(3'd2, 3'd4, 8'h90, 1'b1);
    wait_done1(lat, seen);
    n_cmp++; if ({seen, lat} !== {1'b1, 32'd4}) begin n_bad++; $display("FAIL sra_latency got seen=%b lat=%0d want 1 4", seen, lat); end
    n_cmp++; if ({q1, so1} !== {8'hF9, 1'b0}) begin n_bad++; $display("FAIL sra_result got %h %b want f9 0", q1, so1); end
    n_cmp++; if (q4 !== 8'hF9) begin n_bad++; $display("FAIL sra_step4 got %h want f9", q4); end
    tick();
    issue(3'd1, 3'd4, 8'h90, 1'b1);
    wait_done1(lat, seen);
    n_cmp++; if ({seen, q1, so1} !== {1'b1, 8'hF9, 1'b0}) begin n_bad++; $display("FAIL srl_result got %b %h %b want 1 f9 0", seen, q1, so1); end
    tick();
  endtask

  task automatic test_rotate();
    int   lat;
    logic seen;
    issue(3'd4, 3'd1, 8'h81, 1'b0);
    wait_done1(lat, seen);
    n_cmp++; if ({seen, lat, q1, so1} !== {1'b1, 32'd1, 8'hC0, 1'b1}) begin n_bad++; $display("FAIL ror_result got %b %0d %h %b want 1 1 c0 1", seen, lat, q1, so1); end
    tick();
    issue(3'd3, 3'd7, 8'h81, 1'b1);
    wait_done1(lat, seen);
    n_cmp++; if ({seen, lat, q1, so1} !== {1'b1, 32'd7, 8'hC0, 1'b0}) begin n_bad++; $display("FAIL rol_result got %b %0d %h %b want 1 7 c0 0", seen, lat, q1, so1); end
    n_cmp++; if (q4 !== 8'hC0) begin n_bad++; $display("FAIL rol_step4 got %h want c0", q4); end
    tick();
  endtask

  task automatic test_hold();
    int   lat;
    logic seen;
    // ser_out is 0 here (left by ROL); a hold op must not touch it or q.
    issue(3'd5, 3'd3, 8'hA5, 1'b1);
    wait_done1(lat, seen);
    n_cmp++; if ({seen, lat} !== {1'b1, 32'd3}) begin n_bad++; $display("FAIL hold_latency got seen=%b lat=%0d want 1 3", seen, lat); end
    n_cmp++; if ({q1, so1} !== {8'hA5, 1'b0}) begin n_bad++; $display("FAIL hold_result got %h %b want a5 0", q1, so1); end
    tick();
  endtask

  task automatic test_zero_amt();
    issue(3'd0, 3'd0, 8'h5A, 1'b0);  // E0
    n_cmp++; if ({q1, done1, busy1} !== {8'h5A, 2'b11}) begin n_bad++; $display("FAIL zero_e0 got %h %b %b want 5a 1 1", q1, done1, busy1); end
    start = 1'b1; d = 8'h11; amt = 3'd3;  // re-pulse during DONE
    tick();
    start = 1'b0;
    n_cmp++; if ({q1, done1, busy1} !== {8'h5A, 2'b00}) begin n_bad++; $display("FAIL zero_repulse got %h %b %b want 5a 0 0", q1, done1, busy1); end
    tick();
    n_cmp++; if ({q1, busy1, q4, busy4} !== {8'h5A, 1'b0, 8'h5A, 1'b0}) begin n_bad++; $display("FAIL zero_stay_idle got %h %b %h %b want 5a 0 5a 0", q1, busy1, q4, busy4); end
  endtask

  task automatic test_step4();
    int   lat;
    logic seen;
    issue(3'd0, 3'd6, 8'hFF, 1'b0);
    tick();  // E1
    n_cmp++; if ({q4, so4, done4, busy4} !== {8'hF0, 3'b101}) begin n_bad++; $display("FAIL step4_sll_e1 got %h %b %b %b want f0 1 0 1", q4, so4, done4, busy4); end
    tick();  // E2
    n_cmp++; if ({q4, so4, done4} !== {8'hC0, 2'b11}) begin n_bad++; $display("FAIL step4_sll_e2 got %h %b %b want c0 1 1", q4, so4, done4); end
    tick();  // E3
    n_cmp++; if ({q4, done4, busy4} !== {8'hC0, 2'b00}) begin n_bad++; $display("FAIL step4_sll_e3 got %h %b %b want c0 0 0", q4, done4, busy4); end
    wait_done1(lat, seen);
    n_cmp++; if ({seen, lat, q1} !== {1'b1, 32'd3, 8'hC0}) begin n_bad++; $display("FAIL step1_sll6 got %b %0d %h want 1 3 c0", seen, lat, q1); end
    tick();
    issue(3'd1, 3'd5, 8'h00, 1'b1);
    tick();  // E1
    n_cmp++; if ({q4, so4, done4} !== {8'hF0, 2'b00}) begin n_bad++; $display("FAIL step4_srl_e1 got %h %b %b want f0 0 0", q4, so4, done4); end
    tick();  // E2
    n_cmp++; if ({q4, so4, done4} !== {8'hF8, 2'b01}) begin n_bad++; $display("FAIL step4_srl_e2 got %h %b %b want f8 0 1", q4, so4, done4); end
    wait_done1(lat, seen);
    n_cmp++; if ({seen, lat, q1} !== {1'b1, 32'd3, 8'hF8}) begin n_bad++; $display("FAIL step1_srl5 got %b %0d %h want 1 3 f8", seen, lat, q1); end
    tick();
  endtask

  task automatic test_back_to_back();
    op = 3'd1; amt = 3'd1; d = 8'hF0; ser_in = 1'b0; start = 1'b1;
    tick();  // E0
    tick();  // E1
    n_cmp++; if ({q1, done1} !== {8'h78, 1'b1}) begin n_bad++; $display("FAIL b2b_first got %h %b want 78 1", q1, done1); end
    tick();  // E2: back in IDLE, start still high
    n_cmp++; if ({busy1, done1, q1} !== {2'b00, 8'h78}) begin n_bad++; $display("FAIL b2b_idle_gap got %b %b %h want 0 0 78", busy1, done1, q1); end
    tick();  // E3: second start accepted
    start = 1'b0;
    n_cmp++; if ({busy1, q1, busy4, q4} !== {1'b1, 8'hF0, 1'b1, 8'hF0}) begin n_bad++; $display("FAIL b2b_restart got %b %h %b %h want 1 f0 1 f0", busy1, q1, busy4, q4); end
    tick();  // E4
    n_cmp++; if ({q1, done1} !== {8'h78, 1'b1}) begin n_bad++; $display("FAIL b2b_second got %h %b want 78 1", q1, done1); end
    tick();
  endtask

  task automatic test_reset_abort();
    logic done_any;
    issue(3'd0, 3'd5, 8'hFF, 1'b0);
    tick(); tick();  // E1, E2
    n_cmp++; if (q1 !== 8'hFC) begin n_bad++; $display("FAIL abort_pre got %h want fc", q1); end
    rst = 1'b0;
    tick();
    n_cmp++; if ({q1, busy1, done1, so1, busy4, done4} !== {8'h00, 5'b00000}) begin n_bad++; $display("FAIL abort_reset got %h %b %b %b %b %b want 00 0 0 0 0 0", q1, busy1, done1, so1, busy4, done4); end
    rst = 1'b1;
    done_any = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      done_any = done_any | done1 | done4 | busy1;
    end
    n_cmp++; if (done_any !== 1'b0) begin n_bad++; $display("FAIL abort_no_done got %b want 0", done_any); end
    ld = 1'b1; d = 8'h3C;
    tick();
    ld = 1'b0;
    n_cmp++; if ({q1, done1, busy1, q4, done4} !== {8'h3C, 2'b00, 8'h3C, 1'b0}) begin n_bad++; $display("FAIL ld_idle got %h %b %b %h %b want 3c 0 0 3c 0", q1, done1, busy1, q4, done4); end
  endtask

  // test sequence and final report
  initial begin
    test_reset();
    test_sll();
    test_sra_srl();
    test_rotate();
    test_hold();
    test_zero_amt();
    test_step4();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
